// File: rtl/reg_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
// The datapath drives addresses and write data; the register file returns operands.
interface reg_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  RegWrite;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;

    modport master (
        output readReg1, readReg2, writeReg, writeData, RegWrite,
        input  data1, data2
    );

    modport slave (
        input  readReg1, readReg2, writeReg, writeData, RegWrite,
        output data1, data2
    );
endinterface

// File: rtl/reg_file.sv
// General-purpose register file: 2 combinational read ports, 1 synchronous write port,
// register 0 hardwired to zero, asynchronous active-high clear of the whole array.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    reg_file_if.slave   rf
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // NOTE: the array must clear asynchronously, so it is built from resettable flops
    // rather than a RAM macro; non-blocking assignments keep reads before the edge old.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.RegWrite && (rf.writeReg != '0)) begin
            regs[rf.writeReg] <= rf.writeData;
        end
    end

    // Address 0 is forced to zero at the port so it never depends on array contents.
    assign rf.data1 = (rf.readReg1 == '0) ? '0 : regs[rf.readReg1];
    assign rf.data2 = (rf.readReg2 == '0) ? '0 : regs[rf.readReg2];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by randomized traffic
// against an array-based reference model, including asynchronous reset pulses.
module tb_reg_file;
    logic clk = 1'b0;
    logic reset;

    reg_file_if bus ();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] refRegs [32];
    int compared   = 0;
    int mismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refRead(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : refRegs[addr];
    endfunction

    task automatic refClear();
        for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    endtask

    task automatic checkPorts(input string tag);
        checkVal({tag, "/data1"}, bus.data1, refRead(bus.readReg1));
        checkVal({tag, "/data2"}, bus.data2, refRead(bus.readReg2));
    endtask

    // Inputs are applied at the falling edge; ports are checked before and after the rising edge.
    task automatic runCycle(input string tag);
        #1 checkPorts({tag, "/pre"});
        @(posedge clk);
        if (!reset && bus.RegWrite && bus.writeReg != 5'd0) refRegs[bus.writeReg] = bus.writeData;
        #1 checkPorts({tag, "/post"});
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        bus.RegWrite  = we;
        bus.writeReg  = wa;
        bus.writeData = wd;
        bus.readReg1  = ra1;
        bus.readReg2  = ra2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        refClear();
        drive(1'b1, 5'd0, 32'd69, 5'd0, 5'd23);
        @(negedge clk);

        // Reset held: writes to reg 0 ignored, everything reads zero.
        repeat (3) runCycle("rstHold");
        checkVal("rstHold/data1", bus.data1, 32'd0);
        checkVal("rstHold/data2", bus.data2, 32'd0);

        // Reset dominates a write to reg 1.
        drive(1'b1, 5'd1, 32'd35, 5'd0, 5'd1);
        repeat (2) runCycle("rstWrite");
        checkVal("rstWrite/reg1", bus.data2, 32'd0);

        // First write after reset release.
        reset = 1'b0;
        #1 checkVal("wr1/before", bus.data2, 32'd0);
        @(posedge clk);
        refRegs[1] = 32'd35;
        #1 checkVal("wr1/after", bus.data2, 32'd35);
        @(negedge clk);

        // Register 0 discards writes.
        drive(1'b1, 5'd0, 32'd69, 5'd0, 5'd0);
        runCycle("reg0");
        checkVal("reg0/data1", bus.data1, 32'd0);
        checkVal("reg0/data2", bus.data2, 32'd0);

        // Highest register on both ports.
        drive(1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd31);
        runCycle("reg31");
        checkVal("reg31/data1", bus.data1, 32'hDEADBEEF);
        checkVal("reg31/data2", bus.data2, 32'hDEADBEEF);

        // Write enable low leaves reg 5 untouched.
        drive(1'b0, 5'd5, 32'd7, 5'd5, 5'd1);
        repeat (3) runCycle("noWrite");
        checkVal("noWrite/reg5", bus.data1, 32'd0);

        // Asynchronous clear between clock edges, and a write lost under reset.
        drive(1'b1, 5'd10, 32'h12345678, 5'd10, 5'd10);
        runCycle("reg10");
        checkVal("reg10/data1", bus.data1, 32'h12345678);
        #2 reset = 1'b1;
        refClear();
        #1 checkVal("asyncRst/data1", bus.data1, 32'd0);
        checkVal("asyncRst/data2", bus.data2, 32'd0);
        checkVal("asyncRst/clkLow", {31'd0, clk}, 32'd0);
        bus.writeData = 32'hCAFEF00D;
        @(posedge clk);
        #1 checkVal("asyncRst/writeLost", bus.data1, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 3) != 0), wa, $urandom(),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                refClear();
                #1 checkPorts("rndRst/async");
                @(posedge clk);
                #1 checkPorts("rndRst/edge");
                @(negedge clk);
                reset = 1'b0;
            end else begin
                runCycle("rnd");
            end
        end

        // Sweep every address after random traffic.
        bus.RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.readReg1 = 5'(a);
            bus.readReg2 = 5'(31 - a);
            #1 checkPorts("sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
